// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and defaults shared by the UART receiver and transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 208;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and a one-entry
//               valid/ready holding register; framing/overrun error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uartRxPin,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 frameError,
    output logic                 overrun
);

    localparam int unsigned        c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         c_idx_last  = 3'(DATA_BITS - 1);

    if (DATA_BITS != 8) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be 8");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                 w_rxs;
    logic [c_cnt_w-1:0]   w_cnt_inc;

    uart_rx_state_t       r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_ovr;

    uart_rx_state_t       w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [2:0]           w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_fe_nxt;
    logic                 w_ovr_nxt;
    logic                 w_deliver;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clock),
        .rst (reset),
        .i_d (uartRxPin),
        .o_q (w_rxs)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_fe    <= w_fe_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_fe_nxt    = 1'b0;
        w_ovr_nxt   = 1'b0;
        w_deliver   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_fe_nxt    = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A pop in the delivery cycle frees the slot, so the new byte replaces it.
        if (w_deliver) begin
            if (!r_valid || rxReady) begin
                w_data_nxt  = r_shift;
                w_valid_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end else if (r_valid && rxReady) begin
            w_valid_nxt = 1'b0;
        end
    end

    assign rxData     = r_data;
    assign rxValid    = r_valid;
    assign frameError = r_fe;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire
